// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_pkg
//  Purpose  : Shared stopwatch types and board-derived timing constants.
//  Revision : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;

    localparam int unsigned BTN_DEBOUNCE_CYCLES   = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned BTN_LONG_PRESS_CYCLES = 2 * CLK_HZ;
    localparam int unsigned BTN_REPEAT_CYCLES     = CLK_HZ / 4;

endpackage
`default_nettype wire

// File: rtl/push_button_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : push_button_conditioner_if
//  Purpose  : Raw pad input and conditioned event outputs of one button.
//  Revision : 1.0  initial release
// ============================================================================
interface push_button_conditioner_if;

    logic BTN_RAW;
    logic BTN_LEVEL;
    logic BTN_PRESS;
    logic BTN_RELEASE;
    logic BTN_LONG;

    modport master (
        output BTN_RAW,
        input  BTN_LEVEL,
        input  BTN_PRESS,
        input  BTN_RELEASE,
        input  BTN_LONG
    );

    modport slave (
        input  BTN_RAW,
        output BTN_LEVEL,
        output BTN_PRESS,
        output BTN_RELEASE,
        output BTN_LONG
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchroniser with synchronous active-high reset.
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule
`default_nettype wire

// File: rtl/push_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : push_button_conditioner
//  Purpose  : Synchronise, debounce and turn one pushbutton into press,
//             release and long-press pulses. BTN_AUTOREPEAT_EN adds repeats.
//  Revision : 1.0  initial release
// ============================================================================
module push_button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = BTN_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_CYCLES     = BTN_REPEAT_CYCLES
) (
    input  logic                            MAINCLOCK,
    input  logic                            RESET,
    push_button_conditioner_if.slave        btn_if
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_PRESS_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("push_button_conditioner: cycle parameters out of range");
    end

    logic          s;
    btn_state_t    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          accept;
    logic          holding;
    logic          repeat_fire;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk_i (MAINCLOCK),
        .rst_i (RESET),
        .d_i   (btn_if.BTN_RAW),
        .q_o   (s)
    );

    // A level change is accepted on the edge the counter would reach the limit.
    always_comb begin
        accept  = (s != level_q) && (dcnt_q == DCNT_LAST);
        level_d = accept ? ~level_q : level_q;
        dcnt_d  = '0;
        if (s != level_q && !accept) begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        holding   = (state_q == HELD) || (state_q == RELEASE_WAIT);
        case (state_q)
            IDLE: begin
                if (s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (accept) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else if (!s) begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (!s) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (accept) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (s) begin
                    state_d = HELD;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bounces back into HELD keep the hold count running.
        hcnt_d = hcnt_q;
        if (state_q == PRESS_WAIT && state_d == HELD) begin
            hcnt_d = '0;
        end else if (holding && hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + 1'b1;
        end
        long_d = holding && (hcnt_q == HCNT_LAST) && !release_d;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;

    // Repeats run only once the hold counter has saturated (after BTN_LONG).
    always_comb begin
        rcnt_d      = '0;
        repeat_fire = 1'b0;
        if (holding && hcnt_q == HCNT_MAX && !release_d) begin
            if (rcnt_q == RCNT_LAST) begin
                repeat_fire = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge MAINCLOCK) begin
        if (RESET) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge MAINCLOCK) begin
        if (RESET) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d | repeat_fire;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign btn_if.BTN_LEVEL   = level_q;
    assign btn_if.BTN_PRESS   = press_q;
    assign btn_if.BTN_RELEASE = release_q;
    assign btn_if.BTN_LONG    = long_q;

endmodule
`default_nettype wire

// File: tb/tb_push_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_push_button_conditioner
//  Purpose  : Scoreboard bench for push_button_conditioner (4/20/6 cycles).
//  Revision : 1.0  initial release
// ============================================================================
module tb_push_button_conditioner;
    import stopwatch_pkg::*;

    localparam int unsigned DEB   = 4;
    localparam int unsigned LONGC = 20;
    localparam int unsigned REP   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [31:0] exp_q[$];

    push_button_conditioner_if bif();

    push_button_conditioner #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONGC),
        .REPEAT_CYCLES     (REP)
    ) dut (
        .MAINCLOCK (clk),
        .RESET     (rst),
        .btn_if    (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Event word: edge number, then press/release/long flags.
    function automatic logic [31:0] ev(input int c, input logic p, input logic r, input logic l);
        return {c[28:0], p, r, l};
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bif.BTN_PRESS || bif.BTN_RELEASE || bif.BTN_LONG) begin
            if (exp_q.size() == 0)
                chk("unexpected_pulse", ev(cyc, bif.BTN_PRESS, bif.BTN_RELEASE, bif.BTN_LONG), 32'd0);
            else
                chk("pulse_event", ev(cyc, bif.BTN_PRESS, bif.BTN_RELEASE, bif.BTN_LONG), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [5:0] pat;
        bif.BTN_RAW = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_outputs", {bif.BTN_LEVEL, bif.BTN_PRESS, bif.BTN_RELEASE, bif.BTN_LONG}, 32'd0);
        chk("rst_state", dut.state_q, IDLE);
        chk("rst_dcnt", dut.dcnt_q, 32'd0);
        chk("rst_hcnt", dut.hcnt_q, 32'd0);

        // Clean press held into a long press, then released.
        @(negedge clk); bif.BTN_RAW = 1'b1; t = cyc;
        exp_q.push_back(ev(t + 6, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(t + 26, 1'b0, 1'b0, 1'b1));
`ifdef BTN_AUTOREPEAT_EN
        exp_q.push_back(ev(t + 32, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(t + 38, 1'b1, 1'b0, 1'b0));
`endif
        exp_q.push_back(ev(t + 42, 1'b0, 1'b1, 1'b0));
        wait_cyc(t + 5);  chk("clean_level_pre", bif.BTN_LEVEL, 1'b0);
        wait_cyc(t + 6);  chk("clean_level_post", bif.BTN_LEVEL, 1'b1);
        wait_cyc(t + 36); chk("long_level_held", bif.BTN_LEVEL, 1'b1);
        bif.BTN_RAW = 1'b0;
        wait_cyc(t + 41); chk("rel_level_pre", bif.BTN_LEVEL, 1'b1);
        wait_cyc(t + 42); chk("rel_level_post", bif.BTN_LEVEL, 1'b0);
        wait_cyc(t + 60); chk("sb_drain_long", exp_q.size(), 32'd0);

        // Three-cycle glitch must be ignored.
        @(negedge clk); bif.BTN_RAW = 1'b1; t = cyc;
        repeat (3) @(negedge clk);
        bif.BTN_RAW = 1'b0;
        wait_cyc(t + 5);  chk("glitch_dcnt_peak", dut.dcnt_q, 32'd3);
        wait_cyc(t + 15);
        chk("glitch_level", bif.BTN_LEVEL, 1'b0);
        chk("glitch_dcnt", dut.dcnt_q, 32'd0);
        chk("glitch_state", dut.state_q, IDLE);
        chk("sb_drain_glitch", exp_q.size(), 32'd0);

        // Bouncy press 1,0,1,1,0,1 then high; short hold so no long press.
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bif.BTN_RAW = pat[i];
            if (i == 0) t = cyc;
        end
        exp_q.push_back(ev(t + 11, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(t + 27, 1'b0, 1'b1, 1'b0));
        wait_cyc(t + 10); chk("bounce_level_pre", bif.BTN_LEVEL, 1'b0);
        wait_cyc(t + 21); chk("bounce_level_held", bif.BTN_LEVEL, 1'b1);
        bif.BTN_RAW = 1'b0;
        wait_cyc(t + 60);
        chk("bounce_level_end", bif.BTN_LEVEL, 1'b0);
        chk("sb_drain_bounce", exp_q.size(), 32'd0);

        // Fresh long press, then reset mid-hold with the button still down.
        @(negedge clk); bif.BTN_RAW = 1'b1; t = cyc;
        exp_q.push_back(ev(t + 6, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(t + 26, 1'b0, 1'b0, 1'b1));
        wait_cyc(t + 28);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_outputs", {bif.BTN_LEVEL, bif.BTN_PRESS, bif.BTN_RELEASE, bif.BTN_LONG}, 32'd0);
        chk("midrst_state", dut.state_q, IDLE);
        chk("sb_drain_prereset", exp_q.size(), 32'd0);
        exp_q.push_back(ev(t + 35, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ev(t + 46, 1'b0, 1'b1, 1'b0));
        wait_cyc(t + 34); chk("postrst_level_pre", bif.BTN_LEVEL, 1'b0);
        wait_cyc(t + 35); chk("postrst_level_post", bif.BTN_LEVEL, 1'b1);
        wait_cyc(t + 40); bif.BTN_RAW = 1'b0;
        wait_cyc(t + 70);
        chk("final_level", bif.BTN_LEVEL, 1'b0);
        chk("sb_drain_final", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
